// File: rtl/bee_pkg.sv
// rtl/bee_pkg.sv - shared types and constants for the bee release scheduler
package bee_pkg;

    localparam int NUM_BEES_MAX = 8;
    localparam int IDX_W        = 3;
    // Wide enough for the largest interval plus the 0..15 jitter extension.
    localparam int CNT_W        = 11;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        WAIT    = 2'd1,
        SELECT  = 2'd2,
        RELEASE = 2'd3
    } bee_state_e;

endpackage

// File: rtl/bee_rr_picker.sv
// rtl/bee_rr_picker.sv - rotating-priority search for the first idle bee at or after rrPtr
module bee_rr_picker
    import bee_pkg::*;
#(
    parameter int NUM_BEES = 4
) (
    input  logic [NUM_BEES-1:0] beeIdle,
    input  logic [IDX_W-1:0]    rrPtr,
    output logic                found,
    output logic [IDX_W-1:0]    idx
);

    logic [NUM_BEES_MAX-1:0] w_idle;

    assign w_idle = NUM_BEES_MAX'(beeIdle);

    // Walk offsets from farthest to nearest so the nearest idle bee wins.
    always_comb begin
        logic [IDX_W:0] w_cand;
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = NUM_BEES - 1; k >= 0; k--) begin
            w_cand = {1'b0, rrPtr} + (IDX_W + 1)'(k);
            if (w_cand >= (IDX_W + 1)'(NUM_BEES)) begin
                w_cand = w_cand - (IDX_W + 1)'(NUM_BEES);
            end
            if (w_idle[w_cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bee_release_scheduler.sv
// rtl/bee_release_scheduler.sv - frame-paced round-robin release of idle bees
// Optional reload jitter: define BEE_RELEASE_JITTER_EN.
module bee_release_scheduler
    import bee_pkg::*;
#(
    parameter int         NUM_BEES         = 4,
    parameter int         RELEASE_INTERVAL = 120,
    parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frameTick,
    input  logic                gameActive,
    input  logic [NUM_BEES-1:0] beeIdle,
    output logic [NUM_BEES-1:0] releaseBee,
    output logic [7:0]          releaseCount,
    output logic                stalled
);

    bee_state_e       r_state;
    bee_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_countdown;
    logic [CNT_W-1:0] w_countdown_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_sel_idx;
    logic [IDX_W-1:0] w_sel_idx_nxt;
    logic [7:0]       r_count;
    logic [7:0]       w_count_nxt;
    logic             r_stalled;
    logic             w_stalled_nxt;
    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [CNT_W-1:0] w_reload;

`ifdef BEE_RELEASE_JITTER_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign w_reload = CNT_W'(RELEASE_INTERVAL) + CNT_W'(r_lfsr[3:0]);
`else
    logic w_unused_seed;

    assign w_unused_seed = ^LFSR_SEED;
    assign w_reload      = CNT_W'(RELEASE_INTERVAL);
`endif

    bee_rr_picker #(
        .NUM_BEES (NUM_BEES)
    ) u_picker (
        .beeIdle (beeIdle),
        .rrPtr   (r_rr_ptr),
        .found   (w_found),
        .idx     (w_pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= STOPPED;
            r_countdown <= '0;
            r_rr_ptr    <= '0;
            r_sel_idx   <= '0;
            r_count     <= '0;
            r_stalled   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_countdown <= w_countdown_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_sel_idx   <= w_sel_idx_nxt;
            r_count     <= w_count_nxt;
            r_stalled   <= w_stalled_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_countdown_nxt = r_countdown;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_sel_idx_nxt   = r_sel_idx;
        w_count_nxt     = r_count;
        w_stalled_nxt   = 1'b0;
        case (r_state)
            STOPPED: begin
                if (gameActive) begin
                    w_state_nxt     = WAIT;
                    w_countdown_nxt = w_reload;
                end
            end
            WAIT: begin
                if (!gameActive) begin
                    w_state_nxt     = STOPPED;
                    w_countdown_nxt = '0;
                end else if (frameTick) begin
                    if (r_countdown <= CNT_W'(1)) begin
                        w_state_nxt     = SELECT;
                        w_countdown_nxt = '0;
                    end else begin
                        w_countdown_nxt = r_countdown - CNT_W'(1);
                    end
                end
            end
            SELECT: begin
                if (!gameActive) begin
                    w_state_nxt     = STOPPED;
                    w_countdown_nxt = '0;
                end else if (w_found) begin
                    w_state_nxt   = RELEASE;
                    w_sel_idx_nxt = w_pick;
                end else begin
                    w_stalled_nxt = 1'b1;
                end
            end
            RELEASE: begin
                // The pulse always completes, even if play stops during it.
                if (r_count != 8'hFF) begin
                    w_count_nxt = r_count + 8'd1;
                end
                w_rr_ptr_nxt = (r_sel_idx == IDX_W'(NUM_BEES - 1)) ? '0 : r_sel_idx + IDX_W'(1);
                if (gameActive) begin
                    w_state_nxt     = WAIT;
                    w_countdown_nxt = w_reload;
                end else begin
                    w_state_nxt     = STOPPED;
                    w_countdown_nxt = '0;
                end
            end
            default: begin
                w_state_nxt     = STOPPED;
                w_countdown_nxt = '0;
            end
        endcase
    end

    assign releaseBee   = (r_state == RELEASE) ? (NUM_BEES'(1) << r_sel_idx) : '0;
    assign releaseCount = r_count;
    assign stalled      = r_stalled;

endmodule

// File: doc/bee_release_scheduler.md
Name: bee_release_scheduler

Overview:
- Upstream stage of the per-bee state machines. Decides when and which bee leaves IDLE by issuing a one-cycle, one-hot releaseBee pulse to exactly one idle bee.
- Release timing is paced by the frame tick. Bees are chosen round-robin, so every bee is released in turn.
- Sits between the game-control FSM (gameActive, frameTick) and the array of bee state machines (beeIdle in, releaseBee out).

Parameters:
- NUM_BEES, 4, number of bee state machines served (2..8).
- RELEASE_INTERVAL, 120, frame ticks between releases (1..1023).
- LFSR_SEED, 8'hA5, reset value of the jitter LFSR. Non-zero. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frameTick  input  1  one-cycle pulse, once per video frame
- gameActive  input  1  high while play is running
- beeIdle  input  NUM_BEES  bit i = IDLE state bit of bee i
- releaseBee  output  NUM_BEES  one-hot, one-cycle release pulse; bit i drives bee i's releaseBee
- releaseCount  output  8  total releases issued; saturates at 255
- stalled  output  1  high while a release is due but no bee is idle

Behaviour:
- Clock and reset (already decided): one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk, and has priority over every other input.
- Reset values:
  - state = STOPPED, countdown = 0, rrPtr = 0, selIdx = 0
  - releaseBee = 0, releaseCount = 0, stalled = 0, lfsr = LFSR_SEED
- FSM states: STOPPED, WAIT, SELECT, RELEASE. Outputs are Moore.
- STOPPED:
  - gameActive=1 → WAIT next cycle; load countdown = RELEASE_INTERVAL.
- WAIT:
  - Each frameTick decrements countdown.
  - frameTick with countdown==1 → SELECT.
  - Cycles without frameTick hold the countdown.
- SELECT:
  - Search beeIdle starting at rrPtr, wrapping modulo NUM_BEES. The first set bit becomes selIdx → RELEASE.
  - No bit set → remain in SELECT with stalled=1. Retry every cycle; frameTicks are ignored while stalled.
- RELEASE (lasts exactly one cycle):
  - releaseBee = 1 << selIdx. releaseCount increments, saturating at 255.
  - Next cycle: rrPtr = (selIdx+1) mod NUM_BEES; countdown reloads; state → WAIT.
- Latency: frameTick at cycle t with countdown==1 gives SELECT at t+1 and the releaseBee pulse at t+2 when an idle bee exists.
- gameActive=0:
  - In WAIT or SELECT → STOPPED next cycle, no pulse. countdown and stalled clear; rrPtr and releaseCount hold.
  - In RELEASE, the pulse still completes, then → STOPPED.
- releaseBee is never multi-hot and never asserted outside RELEASE.
- RELEASE_INTERVAL==1: a release is due on every frameTick.
- frameTick arriving in SELECT or RELEASE is dropped; it is not queued.

Optional Feature:
- Macro: BEE_RELEASE_JITTER_EN.
- Defined:
  - 8-bit Fibonacci LFSR with taps 8,6,5,4, advancing every cycle out of reset.
  - Every countdown reload is RELEASE_INTERVAL + lfsr[3:0] (0..15 extra ticks).
- Undefined: no LFSR is instantiated; the reload is exactly RELEASE_INTERVAL.

Decomposition:
- Shared package bee_pkg holds:
  - the state enum (STOPPED, WAIT, SELECT, RELEASE)
  - a NUM_BEES_MAX=8 constant
  - the countdown width constant (11 bits, so the jitter sum fits)
- One sub-module is natural: bee_rr_picker, a combinational rotating-priority encoder with inputs (beeIdle, rrPtr) and outputs (found, idx).
- The LFSR is inline under the macro.

Test Plan:
- Reset then gameActive=1, all beeIdle=1, RELEASE_INTERVAL=3, frameTick every 4 cycles:
  - releaseBee=0001 exactly 2 cycles after the 3rd frameTick.
  - Subsequent releases go 0010, 0100, 1000, 0001.
  - releaseCount=5 after the 5th release.
- beeIdle=0000 when a release is due:
  - stalled=1 and no pulse.
  - Set beeIdle=0100 → releaseBee=0100 one cycle later; stalled=0.
- rrPtr=2, beeIdle=0011:
  - Selection wraps, releaseBee=0001; the next pick starts at bee 1.
- gameActive drops while in SELECT with stalled=1:
  - STOPPED next cycle, no pulse, stalled=0.
  - releaseCount is unchanged.
- Assert reset mid-countdown while in RELEASE:
  - Next cycle all outputs 0, state STOPPED.
  - The pulse issued in the reset cycle is not counted after reset.
- With BEE_RELEASE_JITTER_EN, run 256 releases at RELEASE_INTERVAL=8:
  - Every measured gap is between 8 and 23 frameTicks.
  - releaseCount saturates at 255.
